// File: rtl/dmem_io_responder.sv
// Responder for the processor data-memory port: steers each access to the dmem syncram
// or to a small I/O page (TX byte FIFO, status, cycle counter, scratch).
module dmem_io_responder #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] IO_BASE    = 12'hF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [11:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [11:0] OFF_TXDATA  = 12'd0;
  localparam logic [11:0] OFF_STATUS  = 12'd1;
  localparam logic [11:0] OFF_CYCLE   = 12'd2;
  localparam logic [11:0] OFF_SCRATCH = 12'd3;

  function automatic logic [31:0] pack_status(input logic [CNT_W-1:0] cnt,
                                              input logic ovf,
                                              input logic is_full,
                                              input logic is_empty);
    logic [3:0] cnt4;
    cnt4 = 4'(cnt);
    return {24'b0, cnt4, 1'b0, ovf, is_full, is_empty};
  endfunction

  logic             io_hit;
  logic [11:0]      io_off;
  logic             wr_tx, wr_status, wr_cycle, wr_scratch;
  logic             fifo_full, fifo_empty;
  logic             pop, push_ok, ovf_set, ovf_clr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic             overflow;
  logic [31:0]      cycle_cnt;
  logic [31:0]      scratch;
  logic [31:0]      io_rd_val;

  // Stage p0: combinational decode of the presented access
  assign io_hit      = (address_dmem >= IO_BASE);
  assign io_off      = address_dmem - IO_BASE;
  assign ram_address = address_dmem;
  assign ram_data    = data;
  assign ram_wren    = wren && !io_hit;

  assign wr_tx      = wren && io_hit && (io_off == OFF_TXDATA);
  assign wr_status  = wren && io_hit && (io_off == OFF_STATUS);
  assign wr_cycle   = wren && io_hit && (io_off == OFF_CYCLE);
  assign wr_scratch = wren && io_hit && (io_off == OFF_SCRATCH);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
  assign pop     = tx_valid && tx_ready;
  assign push_ok = wr_tx && (!fifo_full || pop);
  assign ovf_set = wr_tx && fifo_full && !pop;
  assign ovf_clr = wr_status && data[2];

  always_comb begin
    io_rd_val = 32'h0;
    case (io_off)
      OFF_STATUS:  io_rd_val = pack_status(count, overflow, fifo_full, fifo_empty);
      OFF_CYCLE:   io_rd_val = cycle_cnt + 32'd1;
      OFF_SCRATCH: io_rd_val = scratch;
      default:     io_rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'h0;
      scratch   <= 32'h0;
    end else begin
      cycle_cnt <= wr_cycle ? data : cycle_cnt + 32'd1;
      if (wr_scratch) scratch <= data;
    end
  end

  // Stage p1: registered read select and I/O read data, aligned with syncram latency
  logic        rd_vld_p1;
  logic        sel_p1;
  logic [31:0] io_q_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_vld_p1 <= 1'b0;
      sel_p1    <= 1'b0;
      io_q_p1   <= 32'h0;
    end else begin
      rd_vld_p1 <= 1'b1;
      sel_p1    <= io_hit;
      if (io_hit) io_q_p1 <= io_rd_val;
    end
  end

  assign q_dmem = !rd_vld_p1 ? 32'h0 : (sel_p1 ? io_q_p1 : ram_q);

endmodule

// File: tb/tb_dmem_io_responder.sv
// Directed bench for dmem_io_responder with a behavioural one-cycle syncram behind it.
module tb_dmem_io_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [11:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_checks = 0;
  int n_errors = 0;
  int wren_pulses = 0;
  logic [31:0] ram_mem [4096];

  dmem_io_responder #(.FIFO_DEPTH(8), .IO_BASE(12'hF00)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = 32'h0;
    ram_q = 32'h0;
  end

  always @(posedge clock) begin
    if (ram_wren) begin
      ram_mem[ram_address] <= ram_data;
      wren_pulses <= wren_pulses + 1;
    end
    ram_q <= ram_mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: inputs change on the falling edge, outputs settle 1 unit after the rising edge.
  task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic we, input logic rdy);
    @(negedge clock);
    address_dmem = a;
    data         = d;
    wren         = we;
    tx_ready     = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; address_dmem = 12'h0; data = 32'h0; wren = 1'b0; tx_ready = 1'b0;
    #12;
    chk("rst_q", q_dmem, 32'h0);
    chk("rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_txdata", {24'b0, tx_data}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("rst_status", q_dmem, 32'h1);

    // RAM store then load
    cyc(12'h010, 32'h1234ABCD, 1'b1, 1'b0);
    cyc(12'h010, 32'h0, 1'b0, 1'b0);
    chk("ram_load", q_dmem, 32'h1234ABCD);
    chk("ram_wren_once", wren_pulses, 32'd1);
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("ram_no_io_change", q_dmem, 32'h1);

    // Overfill FIFO by one, then drain
    for (int i = 0; i < 9; i++) cyc(12'hF00, 32'h41 + i, 1'b1, 1'b0);
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("full_status", q_dmem, 32'h86);
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", {31'b0, tx_valid}, 32'h1);
      chk("drain_byte", {24'b0, tx_data}, 32'h41 + i);
      cyc(12'h000, 32'h0, 1'b0, 1'b1);
    end
    chk("drained_valid", {31'b0, tx_valid}, 32'h0);
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("drained_status", q_dmem, 32'h5);
    cyc(12'hF01, 32'h4, 1'b1, 1'b0);
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("ovf_cleared", q_dmem, 32'h1);

    // Push into a full FIFO on the same edge as a pop
    for (int i = 0; i < 8; i++) cyc(12'hF00, 32'h50 + i, 1'b1, 1'b0);
    cyc(12'hF00, 32'h5A, 1'b1, 1'b1);
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("full_pop_push_status", q_dmem, 32'h82);
    for (int i = 0; i < 8; i++) begin
      chk("pp_byte", {24'b0, tx_data}, (i == 7) ? 32'h5A : 32'h51 + i);
      cyc(12'h000, 32'h0, 1'b0, 1'b1);
    end
    chk("pp_empty", {31'b0, tx_valid}, 32'h0);

    // Cycle counter load and wrap
    cyc(12'hF02, 32'hFFFFFFFE, 1'b1, 1'b0);
    cyc(12'hF02, 32'h0, 1'b0, 1'b0);
    chk("cycle_0", q_dmem, 32'hFFFFFFFF);
    cyc(12'hF02, 32'h0, 1'b0, 1'b0);
    chk("cycle_1", q_dmem, 32'h00000000);
    cyc(12'hF02, 32'h0, 1'b0, 1'b0);
    chk("cycle_2", q_dmem, 32'h00000001);

    // Scratch, unmapped read, RAM after I/O
    cyc(12'hF03, 32'hDEADBEEF, 1'b1, 1'b0);
    cyc(12'hF07, 32'h0, 1'b0, 1'b0);
    chk("unmapped", q_dmem, 32'h0);
    cyc(12'hF03, 32'h0, 1'b0, 1'b0);
    chk("scratch", q_dmem, 32'hDEADBEEF);
    cyc(12'h010, 32'h0, 1'b0, 1'b0);
    chk("ram_after_io", q_dmem, 32'h1234ABCD);
    cyc(12'hF03, 32'h11111111, 1'b1, 1'b0);
    chk("rdw_old", q_dmem, 32'hDEADBEEF);
    cyc(12'hF03, 32'h0, 1'b0, 1'b0);
    chk("rdw_new", q_dmem, 32'h11111111);
    chk("io_no_ram_wren", wren_pulses, 32'd1);

    // Asynchronous reset with three bytes queued
    for (int i = 0; i < 3; i++) cyc(12'hF00, 32'h60 + i, 1'b1, 1'b0);
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("three_status", q_dmem, 32'h30);
    cyc(12'hF03, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_q", q_dmem, 32'h11111111);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, tx_valid}, 32'h0);
    chk("arst_q", q_dmem, 32'h0);
    @(negedge clock);
    address_dmem = 12'h000; wren = 1'b0;
    reset = 1'b1;
    cyc(12'hF01, 32'h0, 1'b0, 1'b0);
    chk("arst_status", q_dmem, 32'h1);
    cyc(12'hF03, 32'h0, 1'b0, 1'b0);
    chk("arst_scratch", q_dmem, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
